// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bus: ID/EX hazard inputs, stall requests, pipeline control outputs and status.
interface pipeline_hazard_ctrl_if;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 32;

    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_memread;
    logic             ex_branch_taken;
    logic             ex_mdu_start;
    logic             mdu_done;
    logic             imem_busywait;
    logic             dmem_busywait;

    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_hold;
    logic             id_ex_bubble;
    logic             ex_mem_hold;
    logic             ex_mem_bubble;
    logic [1:0]       state;
    logic             mdu_err_flag;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Pipeline side: supplies hazard inputs, consumes control outputs
    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memread,
               ex_branch_taken, ex_mdu_start, mdu_done, imem_busywait, dmem_busywait,
        input  pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_bubble,
               ex_mem_hold, ex_mem_bubble, state, mdu_err_flag, stall_cnt, flush_cnt
    );

    // Controller side
    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memread,
               ex_branch_taken, ex_mdu_start, mdu_done, imem_busywait, dmem_busywait,
        output pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_bubble,
               ex_mem_hold, ex_mem_bubble, state, mdu_err_flag, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory stalls, branch flush, MDU wait with watchdog, load-use stall.
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN; otherwise the
// counter outputs are tied to zero and no counter registers exist.
module pipeline_hazard_ctrl (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = 32;
    localparam int unsigned WD_W  = 6;
    localparam logic [WD_W-1:0] WD_MAX = '1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MDU_WAIT = 2'b01,
        ST_MDU_ERR  = 2'b10
    } state_t;

    state_t          state;
    logic [WD_W-1:0] wd;
    logic            err_flag;

    logic in_run;
    logic lu_hazard;
    logic mdu_stall;
    logic br_flush;

    // Hazard decode from current state and inputs
    always_comb begin
        in_run    = (state == ST_RUN);
        lu_hazard = in_run && bus.ex_memread && (bus.ex_rd != '0) &&
                    ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));
        // The MDU op must stay in EX from its first cycle until its result is valid
        mdu_stall = (state == ST_MDU_ERR) ||
                    ((state == ST_MDU_WAIT) && !bus.mdu_done) ||
                    (in_run && !bus.ex_branch_taken && bus.ex_mdu_start && !bus.mdu_done);
        br_flush  = !reset && !bus.dmem_busywait && in_run && bus.ex_branch_taken;
    end

    // Prioritised control outputs, idle pattern by default
    always_comb begin
        bus.pc_write      = 1'b1;
        bus.if_id_write   = 1'b1;
        bus.if_id_flush   = 1'b0;
        bus.id_ex_hold    = 1'b0;
        bus.id_ex_bubble  = 1'b0;
        bus.ex_mem_hold   = 1'b0;
        bus.ex_mem_bubble = 1'b0;
        if (!reset) begin
            if (bus.dmem_busywait) begin
                bus.pc_write    = 1'b0;
                bus.if_id_write = 1'b0;
                bus.id_ex_hold  = 1'b1;
                bus.ex_mem_hold = 1'b1;
            end else if (mdu_stall) begin
                bus.pc_write      = 1'b0;
                bus.if_id_write   = 1'b0;
                bus.id_ex_hold    = 1'b1;
                bus.ex_mem_bubble = 1'b1;
            end else if (br_flush) begin
                bus.if_id_flush  = 1'b1;
                bus.id_ex_bubble = 1'b1;
            end else if (lu_hazard) begin
                bus.pc_write     = 1'b0;
                bus.if_id_write  = 1'b0;
                bus.id_ex_bubble = 1'b1;
            end else if (in_run && bus.imem_busywait) begin
                bus.pc_write    = 1'b0;
                bus.if_id_flush = 1'b1;
            end
        end
    end

    // MDU state machine and watchdog; frozen while data memory stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            wd       <= '0;
            err_flag <= 1'b0;
        end else if (!bus.dmem_busywait) begin
            case (state)
                ST_RUN: begin
                    if (!bus.ex_branch_taken && bus.ex_mdu_start && !bus.mdu_done) begin
                        state <= ST_MDU_WAIT;
                        wd    <= '0;
                    end
                end
                ST_MDU_WAIT: begin
                    if (bus.mdu_done) begin
                        state <= ST_RUN;
                    end else begin
                        wd <= wd + WD_W'(1);
                        if ((wd + WD_W'(1)) == WD_MAX) begin
                            state    <= ST_MDU_ERR;
                            err_flag <= 1'b1;
                        end
                    end
                end
                ST_MDU_ERR: state <= ST_MDU_ERR;
                default:    state <= ST_RUN;
            endcase
        end
    end

    assign bus.state        = state;
    assign bus.mdu_err_flag = err_flag;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // Saturating stall and branch-flush counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!bus.pc_write && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (br_flush && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
`else
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed per-cycle vectors with hand-computed
// control patterns and states; a monitor pops expectations each cycle and compares.
module tb_pipeline_hazard_ctrl;
    // {pc_write, if_id_write, if_id_flush, id_ex_hold, id_ex_bubble, ex_mem_hold, ex_mem_bubble}
    localparam logic [6:0] C_IDLE = 7'b1100000;
    localparam logic [6:0] C_DM   = 7'b0001010;
    localparam logic [6:0] C_BR   = 7'b1110100;
    localparam logic [6:0] C_MDU  = 7'b0001001;
    localparam logic [6:0] C_LU   = 7'b0000100;
    localparam logic [6:0] C_IM   = 7'b0110000;
    localparam logic [1:0] S_RUN  = 2'b00;
    localparam logic [1:0] S_WAIT = 2'b01;
    localparam logic [1:0] S_ERR  = 2'b10;

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       memread;
        logic       branch;
        logic       start;
        logic       done;
        logic       imem;
        logic       dmem;
    } stim_t;

    typedef struct {
        string       name;
        logic [6:0]  ctl;
        logic [1:0]  st;
        logic        flag;
        logic        regs;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] stall_m = '0;
    logic [31:0] flush_m = '0;
    stim_t s;
    exp_t  q[$];

    pipeline_hazard_ctrl_if bus();

    pipeline_hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic clr();
        s = '{default: '0};
    endtask

    // Apply staged inputs for one cycle and queue the expected response
    task automatic step(input string name, input logic [6:0] ctl, input logic [1:0] st,
                        input logic flag, input logic regs);
        exp_t e;
        @(posedge clk);
        #1;
        reset               = s.rst;
        bus.id_rs1          = s.rs1;
        bus.id_rs2          = s.rs2;
        bus.id_uses_rs1     = s.u1;
        bus.id_uses_rs2     = s.u2;
        bus.ex_rd           = s.rd;
        bus.ex_memread      = s.memread;
        bus.ex_branch_taken = s.branch;
        bus.ex_mdu_start    = s.start;
        bus.mdu_done        = s.done;
        bus.imem_busywait   = s.imem;
        bus.dmem_busywait   = s.dmem;
        e.name  = name;
        e.ctl   = ctl;
        e.st    = st;
        e.flag  = flag;
        e.regs  = regs;
        e.stall = stall_m;
        e.flush = flush_m;
        q.push_back(e);
        if (s.rst) begin
            stall_m = '0;
            flush_m = '0;
        end else begin
`ifdef HAZARD_PERF_CNT_EN
            if (!ctl[6]) stall_m = stall_m + 32'd1;
            if (ctl == C_BR) flush_m = flush_m + 32'd1;
`endif
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle
    initial begin
        exp_t e;
        logic [6:0] got;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                got = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_hold,
                       bus.id_ex_bubble, bus.ex_mem_hold, bus.ex_mem_bubble};
                checks++;
                if (got !== e.ctl) begin
                    errors++;
                    $display("FAIL %s ctl: got %b expected %b", e.name, got, e.ctl);
                end
                if (e.regs) begin
                    checks += 4;
                    if (bus.state !== e.st) begin
                        errors++;
                        $display("FAIL %s state: got %b expected %b", e.name, bus.state, e.st);
                    end
                    if (bus.mdu_err_flag !== e.flag) begin
                        errors++;
                        $display("FAIL %s err_flag: got %b expected %b", e.name, bus.mdu_err_flag, e.flag);
                    end
                    if (bus.stall_cnt !== e.stall) begin
                        errors++;
                        $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, bus.stall_cnt, e.stall);
                    end
                    if (bus.flush_cnt !== e.flush) begin
                        errors++;
                        $display("FAIL %s flush_cnt: got %0d expected %0d", e.name, bus.flush_cnt, e.flush);
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        s.rst = 1'b1;
        step("por", C_IDLE, S_RUN, 1'b0, 1'b0);
        clr(); s.rst = 1'b1; s.dmem = 1'b1; s.branch = 1'b1; s.start = 1'b1;
        step("rst_override", C_IDLE, S_RUN, 1'b0, 1'b1);
        clr(); step("idle", C_IDLE, S_RUN, 1'b0, 1'b1);

        // Load-use detection and its qualifiers
        clr(); s.memread = 1'b1; s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1'b1;
        step("lu_rs2", C_LU, S_RUN, 1'b0, 1'b1);
        clr(); step("lu_one_cycle", C_IDLE, S_RUN, 1'b0, 1'b1);
        clr(); s.memread = 1'b1; s.rd = 5'd0; s.rs2 = 5'd0; s.u2 = 1'b1;
        step("lu_x0", C_IDLE, S_RUN, 1'b0, 1'b1);
        clr(); s.memread = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.u1 = 1'b1;
        step("lu_rs1", C_LU, S_RUN, 1'b0, 1'b1);
        clr(); s.memread = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7;
        step("lu_not_used", C_IDLE, S_RUN, 1'b0, 1'b1);
        clr(); s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1'b1;
        step("lu_no_load", C_IDLE, S_RUN, 1'b0, 1'b1);

        // Priority ordering
        clr(); s.memread = 1'b1; s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1'b1; s.branch = 1'b1;
        step("br_over_lu", C_BR, S_RUN, 1'b0, 1'b1);
        clr(); s.imem = 1'b1;
        step("imem", C_IM, S_RUN, 1'b0, 1'b1);
        clr(); s.imem = 1'b1; s.memread = 1'b1; s.rd = 5'd3; s.rs1 = 5'd3; s.u1 = 1'b1;
        step("lu_over_imem", C_LU, S_RUN, 1'b0, 1'b1);
        clr(); s.dmem = 1'b1; s.branch = 1'b1;
        step("dmem_over_br", C_DM, S_RUN, 1'b0, 1'b1);
        clr(); s.branch = 1'b1;
        step("br", C_BR, S_RUN, 1'b0, 1'b1);

        // MDU completes after 10 wait cycles
        clr(); s.start = 1'b1;
        step("mdu_start", C_MDU, S_RUN, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            clr();
            if (i == 0) begin
                s.imem = 1'b1; s.branch = 1'b1; s.memread = 1'b1;
                s.rd = 5'd2; s.rs1 = 5'd2; s.u1 = 1'b1;
            end
            step("mdu_wait", C_MDU, S_WAIT, 1'b0, 1'b1);
        end
        clr(); s.done = 1'b1;
        step("mdu_done", C_IDLE, S_WAIT, 1'b0, 1'b1);
        clr(); step("mdu_back_run", C_IDLE, S_RUN, 1'b0, 1'b1);
        clr(); s.start = 1'b1; s.done = 1'b1;
        step("mdu_same_cycle", C_IDLE, S_RUN, 1'b0, 1'b1);
        clr(); step("mdu_same_cycle_run", C_IDLE, S_RUN, 1'b0, 1'b1);

        // Data-memory stall during MDU wait freezes the watchdog
        clr(); s.start = 1'b1;
        step("mdu_start2", C_MDU, S_RUN, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            clr(); step("wd_pre_dmem", C_MDU, S_WAIT, 1'b0, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            clr(); s.dmem = 1'b1;
            step("wd_dmem_hold", C_DM, S_WAIT, 1'b0, 1'b1);
        end
        for (int i = 0; i < 58; i++) begin
            clr(); step("wd_post_dmem", C_MDU, S_WAIT, 1'b0, 1'b1);
        end
        clr(); s.done = 1'b1;
        step("err_ignores_done", C_MDU, S_ERR, 1'b1, 1'b1);
        clr(); s.dmem = 1'b1;
        step("err_dmem", C_DM, S_ERR, 1'b1, 1'b1);
        clr(); s.rst = 1'b1; s.done = 1'b1;
        step("err_reset", C_IDLE, S_ERR, 1'b1, 1'b1);
        clr(); step("err_reset_after", C_IDLE, S_RUN, 1'b0, 1'b1);

        // Uninterrupted watchdog expiry after 63 wait cycles
        clr(); s.start = 1'b1;
        step("mdu_start3", C_MDU, S_RUN, 1'b0, 1'b1);
        for (int i = 0; i < 63; i++) begin
            clr(); step("wd_count", C_MDU, S_WAIT, 1'b0, 1'b1);
        end
        clr(); step("wd_expired", C_MDU, S_ERR, 1'b1, 1'b1);
        clr(); s.rst = 1'b1;
        step("wd_reset", C_IDLE, S_ERR, 1'b1, 1'b1);
        clr(); step("wd_reset_after", C_IDLE, S_RUN, 1'b0, 1'b1);

        // Reset in the middle of an MDU wait
        clr(); s.start = 1'b1;
        step("mdu_start4", C_MDU, S_RUN, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            clr(); step("mid_wait", C_MDU, S_WAIT, 1'b0, 1'b1);
        end
        clr(); s.rst = 1'b1;
        step("mid_wait_reset", C_IDLE, S_WAIT, 1'b0, 1'b1);
        clr(); step("mid_wait_reset_after", C_IDLE, S_RUN, 1'b0, 1'b1);

        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
